shift_reg_queue: RTL and testbench
==================================

Name: shift_reg_queue

Overview:
- Parametrised successor to the team's plain shift-register bank: a DEPTH x WIDTH shift-register array with occupancy tracking and a pop port.
- Run-time mode select: queue (FIFO) or stack (LIFO).
- Provides a full parallel snapshot, an addressed read port, and overflow/underflow flags.
- Sits between a data producer and the datapath stages that consume the register window, for example filter taps or history buffers.

Parameters:
WIDTH, 32, bits per entry
DEPTH, 16, number of entries (>=2)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous, active-high reset
push_i  input  1  shift data_i into entry 0
pop_i  input  1  remove one entry per mode_i
mode_i  input  1  0 = queue (pop oldest), 1 = stack (pop newest)
data_i  input  WIDTH  push data
rd_addr_i  input  $clog2(DEPTH)  read-port index
data_o  output  DEPTH*WIDTH  packed array [DEPTH-1:0][WIDTH-1:0], entry i = data_o[i]
rd_data_o  output  WIDTH  entry[rd_addr_i] if rd_addr_i < count_o, else 0 (combinational)
pop_data_o  output  WIDTH  registered popped value
pop_valid_o  output  1  one-cycle pulse, pop_data_o valid
count_o  output  $clog2(DEPTH+1)  valid entries
full_o  output  1  count_o == DEPTH
empty_o  output  1  count_o == 0
overflow_o  output  1  one-cycle pulse, entry dropped
underflow_o  output  1  one-cycle pulse, pop on empty

Behaviour:
Reset (asynchronous, any time, including mid-operation):
- All entries, count_o, pop_data_o, pop_valid_o, overflow_o and underflow_o go to 0.
- empty_o = 1, full_o = 0.

General rules:
- Entry 0 is always the newest entry. Valid entries are 0..count-1.
- Invalid entries are always 0.
- Pulse outputs default to 0 every cycle.
- pop_data_o holds its value until the next successful pop.
- mode_i is sampled every cycle. Changing it mid-stream is legal and applies to the current contents.

Push only:
- entry[0] <= data_i and entry[i] <= entry[i-1].
- If not full: count++.
- If full: entry[DEPTH-1] is discarded, count stays DEPTH, and overflow_o pulses.

Pop only, not empty:
- Queue mode: pop_data_o <= entry[count-1], entry[count-1] <= 0, count--.
- Stack mode: pop_data_o <= entry[0], entry[i] <= entry[i+1], entry[DEPTH-1] <= 0, count--.
- pop_valid_o pulses on the next cycle, i.e. 1-cycle latency.

Pop only, empty:
- No state change.
- underflow_o pulses. pop_valid_o stays 0.

Push + pop, queue mode, not empty:
- pop_data_o <= pre-shift entry[count-1].
- Then shift in data_i. The slot vacated at index count is zeroed.
- count unchanged. pop_valid_o pulses.
- When full this pops entry[DEPTH-1] and overflow_o does not pulse.

Push + pop, stack mode, not empty:
- Pass-through: pop_data_o <= data_i. Array and count unchanged. pop_valid_o pulses.

Push + pop, empty (either mode):
- Acts as a push only. underflow_o pulses.

Status flags:
- full_o and empty_o are derived combinationally from the count register.

Test Plan:
(All scenarios use WIDTH=8, DEPTH=4.)
1. Reset, then push 0x11, 0x22, 0x33 -> data_o = {0x00, 0x11, 0x22, 0x33} (entry3..entry0), count_o = 3, empty_o = 0, full_o = 0. rd_addr_i = 3 -> rd_data_o = 0.
2. Push 0x11..0x55 (5 pushes) -> after the 4th push full_o = 1. The 5th push pulses overflow_o and leaves entries {0x22, 0x33, 0x44, 0x55}, count_o = 4.
3. Queue mode: after scenario 1, pop x3 -> pop_data_o = 0x11, 0x22, 0x33, each with a pop_valid_o pulse one cycle after its pop. Then empty_o = 1. A 4th pop -> underflow_o = 1, pop_valid_o = 0.
4. Stack mode: push 0xA1, 0xA2, 0xA3, then pop x2 -> pop_data_o = 0xA3, then 0xA2. Ends with count_o = 1, entry0 = 0xA1, other entries 0.
5. Simultaneous push + pop:
   - Queue mode, full with {0x11, 0x22, 0x33, 0x44}, push 0x55 + pop -> pop_data_o = 0x11, entries {0x22, 0x33, 0x44, 0x55}, no overflow_o.
   - Stack mode, push 0x66 + pop -> pop_data_o = 0x66, array unchanged.
   - Push + pop on empty -> count_o = 1 and underflow_o pulses.
6. Assert rst_i asynchronously mid-burst (count 2, pop pending, no clock edge) -> all outputs reset immediately. The first push after release yields count_o = 1.

Source files
------------

// File: rtl/shift_reg_queue_if.sv
// Producer/consumer bundle for shift_reg_queue: push/pop controls, read port,
// parallel snapshot and status pulses.
interface shift_reg_queue_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic                         push_i;
   logic                         pop_i;
   logic                         mode_i;
   logic [WIDTH-1:0]             data_i;
   logic [AW-1:0]                rd_addr_i;
   logic [DEPTH-1:0][WIDTH-1:0]  data_o;
   logic [WIDTH-1:0]             rd_data_o;
   logic [WIDTH-1:0]             pop_data_o;
   logic                         pop_valid_o;
   logic [CW-1:0]                count_o;
   logic                         full_o;
   logic                         empty_o;
   logic                         overflow_o;
   logic                         underflow_o;

   modport master (
      output push_i, pop_i, mode_i, data_i, rd_addr_i,
      input  data_o, rd_data_o, pop_data_o, pop_valid_o, count_o,
             full_o, empty_o, overflow_o, underflow_o
   );

   modport slave (
      input  push_i, pop_i, mode_i, data_i, rd_addr_i,
      output data_o, rd_data_o, pop_data_o, pop_valid_o, count_o,
             full_o, empty_o, overflow_o, underflow_o
   );
endinterface

// File: rtl/shift_reg_queue.sv
// DEPTH x WIDTH shift-register window with occupancy tracking and a FIFO/LIFO
// pop port; entry 0 is always the newest, invalid entries are held at zero.
module shift_reg_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input logic              clk_i,
   input logic              rst_i,
   shift_reg_queue_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] ONE      = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [DEPTH-1:0][WIDTH-1:0] entries_q, entries_d;
   logic [CW-1:0]               count_q, count_d;
   logic [WIDTH-1:0]            pop_data_q, pop_data_d;
   logic                        pop_valid_q, pop_valid_d;
   logic                        overflow_q, overflow_d;
   logic                        underflow_q, underflow_d;

   logic                        full, empty;
   logic [CW-1:0]               top_idx;
   logic [WIDTH-1:0]            top_entry;
   logic [DEPTH-1:0][WIDTH-1:0] shift_up, shift_down;
   logic [WIDTH-1:0]            rd_data;

   assign full    = (count_q == CNT_FULL);
   assign empty   = (count_q == '0);
   assign top_idx = count_q - ONE;

   always_comb begin
      shift_up      = '0;
      shift_down    = '0;
      shift_up[0]   = bus.data_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         shift_up[i]       = entries_q[i-1];
         shift_down[i-1]   = entries_q[i];
      end
   end

   // Oldest valid entry; only meaningful while not empty.
   always_comb begin
      top_entry = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (CW'(i) == top_idx) top_entry = entries_q[i];
      end
   end

   always_comb begin
      rd_data = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (AW'(i) == bus.rd_addr_i && CW'(i) < count_q) rd_data = entries_q[i];
      end
   end

   always_comb begin
      entries_d   = entries_q;
      count_d     = count_q;
      pop_data_d  = pop_data_q;
      pop_valid_d = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;

      // Push on an empty array behaves as a plain push even when popping.
      if (bus.push_i && (!bus.pop_i || empty)) begin
         entries_d   = shift_up;
         underflow_d = bus.pop_i;
         if (full) overflow_d = 1'b1;
         else      count_d    = count_q + ONE;
      end else if (bus.pop_i && empty) begin
         underflow_d = 1'b1;
      end else if (bus.pop_i && !bus.push_i) begin
         pop_valid_d = 1'b1;
         count_d     = count_q - ONE;
         if (bus.mode_i) begin
            pop_data_d = entries_q[0];
            entries_d  = shift_down;
         end else begin
            pop_data_d = top_entry;
            for (int unsigned i = 0; i < DEPTH; i++) begin
               if (CW'(i) == top_idx) entries_d[i] = '0;
            end
         end
      end else if (bus.pop_i && bus.push_i) begin
         pop_valid_d = 1'b1;
         if (bus.mode_i) begin
            pop_data_d = bus.data_i;
         end else begin
            // Oldest leaves, new data enters; the slot the oldest shifts into is cleared.
            pop_data_d = top_entry;
            entries_d  = shift_up;
            for (int unsigned i = 0; i < DEPTH; i++) begin
               if (CW'(i) == count_q) entries_d[i] = '0;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         entries_q   <= '0;
         count_q     <= '0;
         pop_data_q  <= '0;
         pop_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         entries_q   <= entries_d;
         count_q     <= count_d;
         pop_data_q  <= pop_data_d;
         pop_valid_q <= pop_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign bus.data_o      = entries_q;
   assign bus.rd_data_o   = rd_data;
   assign bus.pop_data_o  = pop_data_q;
   assign bus.pop_valid_o = pop_valid_q;
   assign bus.count_o     = count_q;
   assign bus.full_o      = full;
   assign bus.empty_o     = empty;
   assign bus.overflow_o  = overflow_q;
   assign bus.underflow_o = underflow_q;
endmodule

// File: tb/tb_shift_reg_queue.sv
// Bench for shift_reg_queue (WIDTH=8, DEPTH=4): queue-based reference model of
// the array plus a scoreboard of expected popped values.
module tb_shift_reg_queue;
   localparam int W = 8;
   localparam int D = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   shift_reg_queue_if #(.WIDTH(W), .DEPTH(D)) bus ();
   shift_reg_queue #(.WIDTH(W), .DEPTH(D)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] model[$];
   logic [W-1:0] sb[$];
   logic [W-1:0] last_pop = '0;
   logic         exp_ovf, exp_unf, exp_pv;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [D*W-1:0] model_image();
      logic [D*W-1:0] img = '0;
      for (int i = 0; i < D; i++)
         if (i < model.size()) img[i*W +: W] = model[i];
      return img;
   endfunction

   task automatic check_state(input string tag);
      logic [W-1:0] exp_rd;
      check({tag, ".data"}, bus.data_o, model_image());
      check({tag, ".count"}, bus.count_o, model.size());
      check({tag, ".full"}, bus.full_o, model.size() == D);
      check({tag, ".empty"}, bus.empty_o, model.size() == 0);
      exp_rd = (int'(bus.rd_addr_i) < model.size()) ? model[bus.rd_addr_i] : '0;
      check({tag, ".rd_data"}, bus.rd_data_o, exp_rd);
   endtask

   task automatic do_op(input string tag, input bit push, input bit pop, input bit mode,
                        input logic [W-1:0] d);
      bus.push_i    = push;
      bus.pop_i     = pop;
      bus.mode_i    = mode;
      bus.data_i    = d;
      bus.rd_addr_i = 2'($urandom_range(0, D - 1));
      exp_ovf = 1'b0; exp_unf = 1'b0; exp_pv = 1'b0;
      if (push && pop) begin
         if (model.size() == 0) begin
            model.push_front(d);
            exp_unf = 1'b1;
         end else if (!mode) begin
            sb.push_back(model.pop_back());
            model.push_front(d);
            exp_pv = 1'b1;
         end else begin
            sb.push_back(d);
            exp_pv = 1'b1;
         end
      end else if (push) begin
         model.push_front(d);
         if (model.size() > D) begin
            void'(model.pop_back());
            exp_ovf = 1'b1;
         end
      end else if (pop) begin
         if (model.size() == 0) exp_unf = 1'b1;
         else begin
            exp_pv = 1'b1;
            sb.push_back(mode ? model.pop_front() : model.pop_back());
         end
      end
      @(posedge clk);
      #1;
      bus.push_i = 1'b0;
      bus.pop_i  = 1'b0;
      check({tag, ".overflow"}, bus.overflow_o, exp_ovf);
      check({tag, ".underflow"}, bus.underflow_o, exp_unf);
      check({tag, ".pop_valid"}, bus.pop_valid_o, exp_pv);
      if (bus.pop_valid_o) begin
         if (sb.size() == 0) check({tag, ".sb_nonempty"}, 0, 1);
         else begin
            last_pop = sb.pop_front();
            check({tag, ".pop_data"}, bus.pop_data_o, last_pop);
         end
      end else begin
         check({tag, ".pop_hold"}, bus.pop_data_o, last_pop);
      end
      check_state(tag);
   endtask

   task automatic drain(input bit mode);
      while (model.size() > 0) do_op("drain", 1'b0, 1'b1, mode, '0);
   endtask

   initial begin
      bus.push_i = 1'b0; bus.pop_i = 1'b0; bus.mode_i = 1'b0;
      bus.data_i = '0;   bus.rd_addr_i = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.data", bus.data_o, 0);
      check("rst.count", bus.count_o, 0);
      check("rst.empty", bus.empty_o, 1);
      check("rst.full", bus.full_o, 0);
      check("rst.pop_valid", bus.pop_valid_o, 0);
      check("rst.pop_data", bus.pop_data_o, 0);
      @(negedge clk);
      rst = 1'b0;

      // Three pushes, then read beyond the valid range.
      do_op("p1", 1, 0, 0, 8'h11);
      do_op("p2", 1, 0, 0, 8'h22);
      do_op("p3", 1, 0, 0, 8'h33);
      check("s1.data", bus.data_o, 32'h0011_2233);
      bus.rd_addr_i = 2'd3;
      #1;
      check("s1.rd3", bus.rd_data_o, 0);

      // Queue pops oldest first, then underflow.
      do_op("q1", 0, 1, 0, '0);
      check("s3.pop1", bus.pop_data_o, 8'h11);
      do_op("q2", 0, 1, 0, '0);
      check("s3.pop2", bus.pop_data_o, 8'h22);
      do_op("q3", 0, 1, 0, '0);
      check("s3.pop3", bus.pop_data_o, 8'h33);
      do_op("q4", 0, 1, 0, '0);
      check("s3.unf", bus.underflow_o, 1);

      // Fill then overflow.
      for (int i = 1; i <= 5; i++) begin
         do_op("fill", 1, 0, 0, 8'(i * 8'h11));
         if (i == 4) check("s2.full", bus.full_o, 1);
      end
      check("s2.ovf", bus.overflow_o, 1);
      check("s2.data", bus.data_o, 32'h2233_4455);

      // Full queue push+pop: oldest leaves, no overflow.
      drain(1'b0);
      for (int i = 1; i <= 4; i++) do_op("fill2", 1, 0, 0, 8'(i * 8'h11));
      do_op("qpp", 1, 1, 0, 8'h55);
      check("s5.qpp_pop", bus.pop_data_o, 8'h11);
      check("s5.qpp_data", bus.data_o, 32'h2233_4455);
      do_op("spp", 1, 1, 1, 8'h66);
      check("s5.spp_pop", bus.pop_data_o, 8'h66);
      check("s5.spp_data", bus.data_o, 32'h2233_4455);

      // Stack order.
      drain(1'b1);
      do_op("sa1", 1, 0, 1, 8'hA1);
      do_op("sa2", 1, 0, 1, 8'hA2);
      do_op("sa3", 1, 0, 1, 8'hA3);
      do_op("sp1", 0, 1, 1, '0);
      check("s4.pop1", bus.pop_data_o, 8'hA3);
      do_op("sp2", 0, 1, 1, '0);
      check("s4.pop2", bus.pop_data_o, 8'hA2);
      check("s4.data", bus.data_o, 32'h0000_00A1);

      // Push+pop on empty.
      drain(1'b1);
      do_op("epp", 1, 1, 0, 8'h77);
      check("s5.epp_count", bus.count_o, 1);

      // Mixed random traffic with mid-stream mode changes.
      for (int i = 0; i < 80; i++)
         do_op("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 8'($urandom));

      // Async reset mid-burst with a pop pending and no clock edge.
      drain(1'b0);
      do_op("r1", 1, 0, 0, 8'h5A);
      do_op("r2", 1, 0, 0, 8'hC3);
      do_op("r3", 0, 1, 1, '0);
      do_op("r4", 1, 0, 0, 8'h3C);
      bus.pop_i = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("s6.data", bus.data_o, 0);
      check("s6.count", bus.count_o, 0);
      check("s6.empty", bus.empty_o, 1);
      check("s6.pop_data", bus.pop_data_o, 0);
      check("s6.pop_valid", bus.pop_valid_o, 0);
      @(negedge clk);
      rst = 1'b0;
      bus.pop_i = 1'b0;
      model.delete();
      sb.delete();
      last_pop = '0;
      do_op("s6.push", 1, 0, 0, 8'h99);
      check("s6.count1", bus.count_o, 1);

      check("sb.drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
